// File: rtl/bubblesort_engine_if.sv
// Host-side bundle for bubblesort_engine: load/readback bus, sort control, status.
// master = host (drives start/descending/wr_*/rd_addr), slave = engine.
interface bubblesort_engine_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 16
);
    logic              start;
    logic              descending;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  swap_count;
    logic [3:0]        state_out;

    modport master (
        output start, descending, wr_en,
        output wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done,
        input  swap_count, state_out
    );

    modport slave (
        input  start, descending, wr_en,
        input  wr_addr, wr_data, rd_addr,
        output rd_data, busy, done,
        output swap_count, state_out
    );
endinterface

// File: rtl/bubblesort_engine.sv
// In-place bubble sorter over a DEPTH x DATA_W register array, asc/desc at runtime.
// Ports: clk, rst_n (async, active-low), bus (slave modport of bubblesort_engine_if):
//   start/descending in, wr_en/wr_addr/wr_data load port, rd_addr/rd_data readback,
//   busy/done/swap_count/state_out status. Macro BUBBLESORT_EARLY_EXIT_EN enables
//   finishing after the first swap-free pass.
module bubblesort_engine #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    bubblesort_engine_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PASS  = 4'd1,
        CHECK = 4'd2,
        DONE  = 4'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 2);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] j_nx;
    logic              dir;
    logic              armed;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  swap_q;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] nxt;
    logic              out_of_order;
`ifdef BUBBLESORT_EARLY_EXIT_EN
    logic              swapped;
`endif

    assign j_nx         = j + 1'b1;
    assign cur          = mem[j];
    assign nxt          = mem[j_nx];
    assign out_of_order = dir ? (cur < nxt) : (cur > nxt);

    assign bus.rd_data    = mem[bus.rd_addr];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.swap_count = swap_q;
    assign bus.state_out  = state;

    // armed marks the one IDLE cycle between the start edge and the
    // first compare, so busy rises on the edge after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            armed  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            i      <= '0;
            j      <= '0;
            dir    <= 1'b0;
            swap_q <= '0;
`ifdef BUBBLESORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (armed) begin
                        armed  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= PASS;
                    end else begin
                        if (bus.wr_en) begin
                            mem[bus.wr_addr] <= bus.wr_data;
                        end
                        if (bus.start) begin
                            armed  <= 1'b1;
                            i      <= '0;
                            j      <= '0;
                            swap_q <= '0;
                            dir    <= bus.descending;
`ifdef BUBBLESORT_EARLY_EXIT_EN
                            swapped <= 1'b0;
`endif
                        end
                    end
                end
                PASS: begin
                    if (out_of_order) begin
                        mem[j]    <= nxt;
                        mem[j_nx] <= cur;
                        if (swap_q != '1) begin
                            swap_q <= swap_q + 1'b1;
                        end
`ifdef BUBBLESORT_EARLY_EXIT_EN
                        swapped <= 1'b1;
`endif
                    end
                    if (j == LAST - i) begin
                        state <= CHECK;
                    end else begin
                        j <= j_nx;
                    end
                end
                CHECK: begin
`ifdef BUBBLESORT_EARLY_EXIT_EN
                    if (i == LAST || !swapped) begin
`else
                    if (i == LAST) begin
`endif
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        i     <= i + 1'b1;
                        j     <= '0;
                        state <= PASS;
`ifdef BUBBLESORT_EARLY_EXIT_EN
                        swapped <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubblesort_engine.sv
// Self-checking bench for bubblesort_engine: directed cases plus random loads,
// compared against an array-level bubble sort model and expected done timing.
module tb_bubblesort_engine;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int AW = 3;

    logic clk;
    logic rst_n;

    bubblesort_engine_if #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .CNT_W(16)
    ) bus ();
    bubblesort_engine_if #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .CNT_W(4)
    ) bus4 ();

    bubblesort_engine #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bubblesort_engine #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .CNT_W(4)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    assign bus4.start      = bus.start;
    assign bus4.descending = bus.descending;
    assign bus4.wr_en      = bus.wr_en;
    assign bus4.wr_addr    = bus.wr_addr;
    assign bus4.wr_data    = bus.wr_data;
    assign bus4.rd_addr    = bus.rd_addr;

    int cyc = 0;
    int start_cyc = -100;
    int done_cyc = -100;
    int seen_done = -100;
    int exp_sw = 0;
    int checks = 0;
    int failures = 0;
    int m_c;
    int m_p;
    int m_sw;
    logic [15:0] mm [DP];
    logic [15:0] v [DP];
    logic [15:0] e [DP];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare of status outputs against the expected window.
    always @(negedge clk) begin
        bit eb;
        bit ed;
        eb = (cyc > start_cyc) && (cyc <= done_cyc);
        ed = (cyc == done_cyc);
        if (bus.done) seen_done = cyc;
        chk("busy", longint'(bus.busy), longint'(eb));
        chk("done", longint'(bus.done), longint'(ed));
        chk("done_c4", longint'(bus4.done), longint'(ed));
        if (ed) begin
            chk("state_done", longint'(bus.state_out), 3);
            chk("swaps_at_done", longint'(bus.swap_count), exp_sw);
            chk("swaps_c4_at_done", longint'(bus4.swap_count),
                exp_sw > 15 ? 15 : exp_sw);
        end else if (eb) begin
            chk("state_sorting",
                longint'(bus.state_out == 4'd1 ||
                         bus.state_out == 4'd2), 1);
        end else begin
            chk("state_idle", longint'(bus.state_out), 0);
        end
    end

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.descending = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_addr    = '0;
    endtask

    task automatic load(input logic [15:0] d [DP]);
        for (int k = 0; k < DP; k++) begin
            @(posedge clk); #1;
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(k);
            bus.wr_data = d[k];
            mm[k]       = d[k];
        end
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    // Reference: plain bubble sort over the model array.
    task automatic model_sort(input bit desc);
        bit any;
        logic [15:0] t;
        m_c  = 0;
        m_p  = 0;
        m_sw = 0;
        for (int p = 0; p < DP - 1; p++) begin
            any = 1'b0;
            m_p++;
            for (int q = 0; q < DP - 1 - p; q++) begin
                m_c++;
                if (desc ? (mm[q] < mm[q+1]) : (mm[q] > mm[q+1])) begin
                    t       = mm[q];
                    mm[q]   = mm[q+1];
                    mm[q+1] = t;
                    m_sw++;
                    any = 1'b1;
                end
            end
`ifdef BUBBLESORT_EARLY_EXIT_EN
            if (!any) break;
`endif
        end
    endtask

    task automatic begin_sort(input bit desc);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.descending = desc;
        start_cyc      = cyc + 1;
        seen_done      = -100;
        model_sort(desc);
        done_cyc = start_cyc + 1 + m_c + m_p;
        exp_sw   = m_sw;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.descending = ~desc;
    endtask

    task automatic run_sort(input bit desc, input bit inject);
        begin_sort(desc);
        if (inject) begin
            repeat (4) @(posedge clk);
            #1;
            bus.start   = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = 16'hAAAA;
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            while (cyc < done_cyc) begin
                @(posedge clk); #1;
            end
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        while (cyc <= done_cyc) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_mem(input string nm, input logic [15:0] x [DP]);
        for (int k = 0; k < DP; k++) begin
            bus.rd_addr = AW'(k);
            #1;
            chk(nm, longint'(bus.rd_data), longint'(x[k]));
        end
    endtask

    task automatic check_counts(input int n);
        chk("swap_count", longint'(bus.swap_count), n);
        chk("swap_count_c4", longint'(bus4.swap_count), n > 15 ? 15 : n);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < DP; k++) e[k] = '0;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_state", longint'(bus.state_out), 0);
        check_counts(0);
        check_mem("rst_mem", e);
        rst_n = 1'b1;

        // Reverse input, ascending: full work, 28 swaps, done at 36.
        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        load(v);
        run_sort(1'b0, 1'b0);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_mem("rev_asc", e);
        check_counts(28);
        chk("rev_done_edge", seen_done - start_cyc, 36);

        // Already sorted.
        v = '{0, 1, 2, 3, 4, 5, 6, 7};
        load(v);
        run_sort(1'b0, 1'b0);
        check_mem("sorted_asc", e);
        check_counts(0);
`ifdef BUBBLESORT_EARLY_EXIT_EN
        chk("sorted_done_edge", seen_done - start_cyc, 9);
`else
        chk("sorted_done_edge", seen_done - start_cyc, 36);
`endif

        // Duplicates and extremes, descending.
        v = '{3, 9, 3, 16'hFFFF, 0, 9, 1, 3};
        load(v);
        run_sort(1'b1, 1'b0);
        e = '{16'hFFFF, 9, 9, 3, 3, 3, 1, 0};
        check_mem("dup_desc", e);
        check_counts(m_sw);

        // Start and write during sort and in the DONE cycle are ignored.
        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        load(v);
        run_sort(1'b0, 1'b1);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_mem("inject", e);
        check_counts(28);
        chk("inject_done_edge", seen_done - start_cyc, 36);
        repeat (3) @(posedge clk);
        #1;

        // Reset 10 cycles into a sort.
        v = '{5, 1, 4, 1, 5, 9, 2, 6};
        load(v);
        begin_sort(1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        start_cyc = -100;
        done_cyc  = -100;
        #1;
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_state", longint'(bus.state_out), 0);
        chk("midrst_done", longint'(bus.done), 0);
        for (int k = 0; k < DP; k++) begin
            e[k]  = '0;
            mm[k] = '0;
        end
        check_mem("midrst_mem", e);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_done", seen_done, -100);

        // Random loads, direction random, half with many duplicates.
        for (int it = 0; it < 10; it++) begin
            bit d;
            for (int k = 0; k < DP; k++) begin
                v[k] = (it % 2 == 1) ? 16'($urandom_range(0, 3))
                                     : 16'($urandom);
            end
            d = 1'($urandom_range(0, 1));
            load(v);
            run_sort(d, 1'b0);
            check_mem("rand_mem", mm);
            check_counts(m_sw);
            chk("rand_done_edge", seen_done - start_cyc, 1 + m_c + m_p);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
